// File: rtl/mac_array_seq_if.sv
// Byte-stream input, compute-core pin bundle and result port of the dot-product sequencer.
// master = sequencer side, slave = host FIFO / core / result consumer side.
interface mac_array_seq_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [1:0]  core_op;
  logic [5:0]  core_addr;
  logic [7:0]  core_data;
  logic [7:0]  core_dout;
  logic        res_valid;
  logic [18:0] res_data;
  logic        res_ready;

  modport master (
    input  in_valid, in_data, core_dout, res_ready,
    output in_ready, core_op, core_addr, core_data, res_valid, res_data
  );
  modport slave (
    output in_valid, in_data, core_dout, res_ready,
    input  in_ready, core_op, core_addr, core_data, res_valid, res_data
  );
endinterface

// File: rtl/mac_array_seq.sv
// Runs one dot product on the N_MAC-lane MAC core: loads weights/activations, issues READ_S,
// gathers the three result bytes. Optional feature macro: WEIGHT_REUSE_EN (skip LOAD_W on reuse).
module mac_array_seq #(
  parameter int N_MAC  = 8,
  parameter int RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            reuse_w,
  output logic            busy,
  mac_array_seq_if.master bus
);
  localparam int         STAGES   = RD_LAT + 2;
  localparam logic [1:0] OP_LW    = 2'b00;
  localparam logic [1:0] OP_LA    = 2'b01;
  localparam logic [1:0] OP_RD    = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;
  localparam logic [5:0] LAST_IDX = 6'(N_MAC - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_A, S_READ, S_COLLECT, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [5:0]      idx_q, idx_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic [1:0]      core_op_q, core_op_d;
  logic [5:0]      core_addr_q, core_addr_d;
  logic [7:0]      core_data_q, core_data_d;
  logic            res_valid_q, res_valid_d;
  logic [18:0]     res_data_q, res_data_d;
  logic [STAGES:0] vld_pipe_q, vld_pipe_d;
  logic            take_reuse;
  logic            accept;

`ifdef WEIGHT_REUSE_EN
  logic w_loaded_q, w_loaded_d;
  assign take_reuse = reuse_w & w_loaded_q;
`else
  logic unused_reuse_w;
  assign unused_reuse_w = reuse_w;
  assign take_reuse     = 1'b0;
`endif

  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    core_op_d   = OP_NOP;
    core_addr_d = core_addr_q;
    core_data_d = core_data_q;
    res_data_d  = res_data_q;
`ifdef WEIGHT_REUSE_EN
    w_loaded_d  = w_loaded_q;
`endif
    // vld_pipe_q[k] is high in the k-th cycle after READ_S appears on the core pins
    vld_pipe_d  = {vld_pipe_q[STAGES-1:0], state_q == S_READ};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = take_reuse ? S_LOAD_A : S_LOAD_W;
          idx_d   = '0;
        end
      end
      S_LOAD_W: begin
        if (accept) begin
          core_op_d   = OP_LW;
          core_addr_d = idx_q;
          core_data_d = bus.in_data;
          if (idx_q == LAST_IDX) begin
            state_d = S_LOAD_A;
            idx_d   = '0;
`ifdef WEIGHT_REUSE_EN
            w_loaded_d = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      S_LOAD_A: begin
        if (accept) begin
          core_op_d   = OP_LA;
          core_addr_d = idx_q;
          core_data_d = bus.in_data;
          if (idx_q == LAST_IDX) begin
            state_d = S_READ;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      S_READ: begin
        core_op_d = OP_RD;
        state_d   = S_COLLECT;
      end
      S_COLLECT: begin
        // the core's byte 2 only carries three meaningful sum bits
        if (vld_pipe_q[RD_LAT])   res_data_d[18:16] = bus.core_dout[2:0];
        if (vld_pipe_q[RD_LAT+1]) res_data_d[15:8]  = bus.core_dout;
        if (vld_pipe_q[STAGES]) begin
          res_data_d[7:0] = bus.core_dout;
          state_d         = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_LOAD_W) || (state_d == S_LOAD_A);
    busy_d      = state_d != S_IDLE;
    res_valid_d = state_d == S_HOLD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      core_op_q   <= OP_NOP;
      core_addr_q <= '0;
      core_data_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      vld_pipe_q  <= '0;
`ifdef WEIGHT_REUSE_EN
      w_loaded_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      core_op_q   <= core_op_d;
      core_addr_q <= core_addr_d;
      core_data_q <= core_data_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      vld_pipe_q  <= vld_pipe_d;
`ifdef WEIGHT_REUSE_EN
      w_loaded_q  <= w_loaded_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.core_op   = core_op_q;
  assign bus.core_addr = core_addr_q;
  assign bus.core_data = core_data_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_mac_array_seq.sv
// Bench for mac_array_seq: behavioural MAC core on the core pins, dot-product reference
// from the job vectors, directed + randomized jobs.
module tb_mac_array_seq;
  localparam int         N_MAC  = 8;
  localparam int         RD_LAT = 2;
  localparam logic [1:0] OP_LW  = 2'b00;
  localparam logic [1:0] OP_LA  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  logic clk = 1'b0;
  logic rst, start, reuse_w, busy;

  mac_array_seq_if bus();

  mac_array_seq #(.N_MAC(N_MAC), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .reuse_w(reuse_w), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Behavioural core: lane memories, sum on READ_S, bytes 2/1/0 at +RD_LAT..+RD_LAT+2
  logic [7:0]  w_mem [64];
  logic [7:0]  a_mem [64];
  logic [31:0] core_sum;
  int          ph = -1;
  int          bad_addr = 0;
  always @(negedge clk) begin
    if (ph >= 0) ph++;
    if (ph > RD_LAT + 2) ph = -1;
    if ((bus.core_op == OP_LW || bus.core_op == OP_LA) && int'(bus.core_addr) >= N_MAC)
      bad_addr++;
    else if (bus.core_op == OP_LW) w_mem[bus.core_addr] = bus.core_data;
    else if (bus.core_op == OP_LA) a_mem[bus.core_addr] = bus.core_data;
    else if (bus.core_op == OP_RD) begin
      core_sum = 32'd0;
      for (int i = 0; i < N_MAC; i++) core_sum += 32'(w_mem[i]) * 32'(a_mem[i]);
      ph = 0;
    end
    if (ph == RD_LAT)          bus.core_dout = {5'($urandom), core_sum[18:16]};
    else if (ph == RD_LAT + 1) bus.core_dout = core_sum[15:8];
    else if (ph == RD_LAT + 2) bus.core_dout = core_sum[7:0];
    else                       bus.core_dout = 8'($urandom);
  end

  // Pin monitor: every non-NOP op, plus back-to-back LOAD count
  logic [15:0] mon_q[$];
  int          adj_loads = 0;
  logic        prev_load = 1'b0;
  always @(negedge clk) begin
    logic is_load;
    is_load = (bus.core_op == OP_LW) || (bus.core_op == OP_LA);
    if (is_load && prev_load) adj_loads++;
    prev_load = is_load;
    if (bus.core_op == OP_RD) mon_q.push_back({OP_RD, 14'd0});
    else if (is_load) mon_q.push_back({bus.core_op, bus.core_addr, bus.core_data});
  end

  logic [7:0]  wv [N_MAC];
  logic [7:0]  av [N_MAC];
  logic [7:0]  w_last [N_MAC];
  bit          w_ok = 1'b0;
  logic [7:0]  src_q[$];
  bit          alt;
  logic [18:0] got_res;

  // one cycle of byte-stream driving; mode 0 continuous, 1 every other cycle, 2 random
  task automatic step(input int mode);
    bit v, acc;
    v = 1'b0;
    if (src_q.size() > 0) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = alt;
        default: v = 1'($urandom_range(0, 1));
      endcase
      alt = !alt;
    end
    bus.in_valid = v;
    bus.in_data  = v ? src_q[0] : 8'($urandom);
    acc = bus.in_valid && bus.in_ready;
    @(negedge clk);
    if (acc) void'(src_q.pop_front());
  endtask

  task automatic run_job(input string tag, input int mode, input bit reuse, input int hold);
    bit          exp_lw, stable;
    int          edges, ok;
    logic [31:0] sum;
    logic [15:0] exp_tr[$];
    logic [18:0] rd0;
`ifdef WEIGHT_REUSE_EN
    exp_lw = !(reuse && w_ok);
`else
    exp_lw = 1'b1;
`endif
    if (exp_lw) begin
      w_last = wv;
      w_ok   = 1'b1;
    end
    sum = 32'd0;
    src_q.delete();
    for (int i = 0; i < N_MAC; i++) sum += 32'(w_last[i]) * 32'(av[i]);
    if (exp_lw)
      for (int i = 0; i < N_MAC; i++) begin
        exp_tr.push_back({OP_LW, 6'(i), wv[i]});
        src_q.push_back(wv[i]);
      end
    for (int i = 0; i < N_MAC; i++) begin
      exp_tr.push_back({OP_LA, 6'(i), av[i]});
      src_q.push_back(av[i]);
    end
    exp_tr.push_back({OP_RD, 14'd0});

    mon_q.delete();
    adj_loads     = 0;
    alt           = 1'b1;
    bus.res_ready = (hold == 0);
    start         = 1'b1;
    reuse_w       = reuse;
    @(negedge clk);
    start   = 1'b0;
    reuse_w = 1'b0;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);

    edges = 0;
    while (!bus.res_valid && edges < 500) begin
      step(mode);
      edges++;
    end
    check({tag, ".done"}, 32'(bus.res_valid), 32'd1);
    if (mode == 0) check({tag, ".latency"}, 32'(edges), 32'((exp_lw ? 2 : 1) * N_MAC + RD_LAT + 4));
    if (mode == 1) check({tag, ".nop_gaps"}, 32'(adj_loads), 32'd0);
    ok = 0;
    for (int i = 0; i < exp_tr.size() && i < mon_q.size(); i++)
      if (mon_q[i] === exp_tr[i]) ok++;
    check({tag, ".trace_len"}, 32'(mon_q.size()), 32'(exp_tr.size()));
    check({tag, ".trace_ok"}, 32'(ok), 32'(exp_tr.size()));
    got_res = bus.res_data;
    check({tag, ".res"}, 32'(got_res), 32'(sum[18:0]));

    bus.in_valid = 1'b0;
    if (hold > 0) begin
      rd0    = bus.res_data;
      stable = 1'b1;
      repeat (hold) begin
        start = ~start;
        @(negedge clk);
        if (!bus.res_valid || bus.res_data !== rd0) stable = 1'b0;
      end
      check({tag, ".hold_stable"}, 32'(stable), 32'd1);
      start         = 1'b0;
      bus.res_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, ".post_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, ".post_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int edges;
    rst = 1'b1; start = 1'b0; reuse_w = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    check("rst.core_op", 32'(bus.core_op), 32'(OP_NOP));
    check("rst.core_addr", 32'(bus.core_addr), 32'd0);
    check("rst.core_data", 32'(bus.core_data), 32'd0);
    check("rst.res_valid", 32'(bus.res_valid), 32'd0);
    check("rst.res_data", 32'(bus.res_data), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < N_MAC; i++) begin wv[i] = 8'(i + 1); av[i] = 8'd2; end
    run_job("basic", 0, 1'b0, 0);
    check("basic.const", 32'(got_res), 32'h00048);

    for (int i = 0; i < N_MAC; i++) begin wv[i] = 8'hFF; av[i] = 8'hFF; end
    run_job("allff", 0, 1'b0, 0);
    check("allff.const", 32'(got_res), 32'h7F008);

    for (int i = 0; i < N_MAC; i++) begin wv[i] = 8'(i + 1); av[i] = 8'd2; end
    run_job("gappy", 1, 1'b0, 0);
    check("gappy.const", 32'(got_res), 32'h00048);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N_MAC; i++) begin wv[i] = 8'($urandom); av[i] = 8'($urandom); end
      run_job($sformatf("rnd%0d", k), 2, 1'b0, 0);
    end

    for (int i = 0; i < N_MAC; i++) begin wv[i] = 8'($urandom); av[i] = 8'($urandom); end
    run_job("hold", 2, 1'b0, 10);

`ifdef WEIGHT_REUSE_EN
    for (int i = 0; i < N_MAC; i++) begin wv[i] = 8'(i + 1); av[i] = 8'd2; end
    run_job("preload", 0, 1'b0, 0);
    for (int i = 0; i < N_MAC; i++) av[i] = 8'd1;
    run_job("reuse", 0, 1'b1, 0);
    check("reuse.const", 32'(got_res), 32'h00024);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    w_ok = 1'b0;
    run_job("reuse_after_rst", 0, 1'b1, 0);
`else
    for (int i = 0; i < N_MAC; i++) begin wv[i] = 8'($urandom); av[i] = 8'($urandom); end
    run_job("reuse_ignored", 0, 1'b1, 0);
`endif

    // abort partway through the activation phase
    for (int i = 0; i < N_MAC; i++) begin wv[i] = 8'($urandom); av[i] = 8'($urandom); end
    src_q.delete();
    for (int i = 0; i < N_MAC; i++) src_q.push_back(wv[i]);
    for (int i = 0; i < 3; i++) src_q.push_back(av[i]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (src_q.size() > 0 && edges < 100) begin
      step(0);
      edges++;
    end
    check("abort.accepted", 32'(src_q.size()), 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.core_op", 32'(bus.core_op), 32'(OP_NOP));
    check("abort.in_ready", 32'(bus.in_ready), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    w_ok = 1'b0;
    for (int i = 0; i < N_MAC; i++) begin wv[i] = 8'($urandom); av[i] = 8'($urandom); end
    run_job("after_abort", 0, 1'b0, 0);

    check("addr_range", 32'(bad_addr), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mac_array_seq.md
# mac_array_seq

Sequencer that runs one dot product on the 8-lane MAC/adder-tree compute core. It accepts a byte stream of weights and activations on a valid/ready input and drives the core's op/address/data pins with LOAD_W, LOAD_A, READ_S and NOP. It then captures the three serialized result bytes from the core's output and presents the 19-bit sum on a valid/ready result port. It sits between a host-side byte FIFO and the compute core.

## Interface
- N_MAC, 8: MAC lanes; also the number of bytes per load phase (2..64).
- RD_LAT, 2: cycles from the READ_S cycle to the cycle in which core result byte 2 (MSBs) appears on core_dout.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high).
- start  in  1  begin one job; sampled only in IDLE.
- reuse_w  in  1  skip weight load if weights already loaded (see Configuration).
- in_valid  in  1  input byte valid.
- in_data  in  8  weight/activation byte.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- core_op  out  2  to core: 00 LOAD_W, 01 LOAD_A, 10 READ_S, 11 NOP; registered.
- core_addr  out  6  to core lane address; registered.
- core_data  out  8  to core data; registered.
- core_dout  in  8  core serialized result byte.
- res_valid  out  1  result valid.
- res_data  out  19  dot-product sum.
- res_ready  in  1  result consumer ready.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD_W, LOAD_A, READ, COLLECT, HOLD.
- IDLE: start=1 goes to LOAD_W, or to LOAD_A when reuse is taken. idx is set to 0.
- LOAD_W / LOAD_A: in_ready=1. Each accepted byte registers core_op (LOAD_W or LOAD_A), core_addr=idx and core_data=in_data for exactly one cycle, then idx increments.
  - A cycle with no accept drives core_op=NOP.
  - The accept at idx=N_MAC-1 leaves LOAD_W for LOAD_A (idx to 0, w_loaded set), or leaves LOAD_A for READ.
- READ: core_op=READ_S for exactly one cycle, then COLLECT.
- COLLECT: core_op=NOP throughout.
  - Capture core_dout at cycles c+RD_LAT, c+RD_LAT+1 and c+RD_LAT+2, where c is the READ_S cycle.
  - The first capture is byte 2; only bits [2:0] are kept as res_data[18:16].
  - The second capture is byte 1 (res_data[15:8]); the third is byte 0 (res_data[7:0]).
  - After the third capture, go to HOLD.
- HOLD: res_valid=1 and res_data stable until res_ready=1, then IDLE. Holding res_ready high in HOLD gives a one-cycle res_valid pulse.
- in_ready=0 in IDLE, READ, COLLECT and HOLD.
- start is ignored outside IDLE.
- core_op is NOP whenever no LOAD or READ_S is being issued.
- Lanes are written strictly in address order 0..N_MAC-1. Addresses of N_MAC or more are never issued.

## Timing
- Reset values: state=IDLE, in_ready=0, core_op=NOP(11), core_addr=0, core_data=0, res_valid=0, res_data=0, busy=0, idx=0, w_loaded=0.
- rst mid-job: returns to IDLE the next cycle; any partially captured result is discarded. The core's contents are not cleared by this block, and w_loaded=0 forces the next job to reload weights.
- Core pins lag the accepting edge by one cycle.
- Minimum job latency with in_valid held high, from the start cycle to res_valid:
  - 2·N_MAC cycles of loads, then 1 READ cycle, then RD_LAT+3 cycles.
  - This is 22 cycles at the defaults, or 14 cycles with weight reuse.
- Backpressure on in_valid only stretches the LOAD phases. It never changes the READ→capture spacing.

## Configuration
- WEIGHT_REUSE_EN defined: start with reuse_w=1 and w_loaded=1 goes directly to LOAD_A, keeping the core's previous weights. reuse_w=1 with w_loaded=0 still does a full LOAD_W.
- WEIGHT_REUSE_EN undefined: reuse_w is ignored, every job performs LOAD_W, and the w_loaded logic is removed.

## Test plan
- Weights 1..8, activations all 2, in_valid continuous: core_op sequence 00×8 (addr 0..7), 01×8, 10×1. res_data=0x00048, with res_valid in cycle 22 after start.
- Weights and activations all 0xFF: res_data=0x7F008, exercising byte-2 bit truncation.
- Same vectors as the first test with in_valid deasserted on every other cycle: NOP on core_op in each gap, no address skipped, res_data=0x00048.
- res_ready held low for 10 cycles: res_valid and res_data stable, start pulses ignored. After release, IDLE with busy=0 next cycle.
- WEIGHT_REUSE_EN: after the first test, start with reuse_w=1 and activations all 1: no LOAD_W issued, res_data=0x00024. After rst, the same start performs a full LOAD_W.
- rst asserted mid-LOAD_A: next cycle core_op=NOP, in_ready=0, busy=0. A following full job still returns the correct sum.
